// File: rtl/contador_arb.sv
// Round-robin arbiter that grants one of two requesters exclusive use of a shared
// contadorC for a latched run length, and counts rco-high cycles during each run.
module contador_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] mode0,
   input  logic [1:0] mode1,
   input  logic [3:0] D0,
   input  logic [3:0] D1,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   input  logic       rco,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic       enable,
   output logic [1:0] mode,
   output logic [3:0] D,
   output logic [3:0] hits,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_q, state_d;
   logic       win_q, win_d;
   logic       last_q, last_d;
   logic       first_q, first_d;
   logic [1:0] mode_q, mode_d;
   logic [3:0] d_q, d_d;
   logic [3:0] rem_q, rem_d;
   logic [3:0] rco_cnt_q, rco_cnt_d;
   logic [3:0] hits_q, hits_d;
   logic       pick;
   logic [3:0] rco_cnt_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         win_q     <= 1'b0;
         last_q    <= 1'b1;
         first_q   <= 1'b0;
         mode_q    <= 2'b00;
         d_q       <= 4'h0;
         rem_q     <= 4'h0;
         rco_cnt_q <= 4'h0;
         hits_q    <= 4'h0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         last_q    <= last_d;
         first_q   <= first_d;
         mode_q    <= mode_d;
         d_q       <= d_d;
         rem_q     <= rem_d;
         rco_cnt_q <= rco_cnt_d;
         hits_q    <= hits_d;
      end
   end

   always_comb begin
      // On a tie the requester that was not granted last wins.
      pick        = (req0 && req1) ? ~last_q : req1;
      rco_cnt_inc = (rco && (rco_cnt_q != 4'hF)) ? rco_cnt_q + 4'd1 : rco_cnt_q;

      state_d   = state_q;
      win_d     = win_q;
      last_d    = last_q;
      first_d   = first_q;
      mode_d    = mode_q;
      d_d       = d_q;
      rem_d     = rem_q;
      rco_cnt_d = rco_cnt_q;
      hits_d    = hits_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d   = RUN;
               win_d     = pick;
               last_d    = pick;
               first_d   = 1'b1;
               mode_d    = pick ? mode1 : mode0;
               d_d       = pick ? D1 : D0;
               // len-1 wraps 0 to 15, giving the 16-cycle run for len = 0.
               rem_d     = (pick ? len1 : len0) - 4'd1;
               rco_cnt_d = 4'h0;
            end
         end
         RUN: begin
            first_d   = 1'b0;
            rco_cnt_d = rco_cnt_inc;
            if (rem_q == 4'h0) begin
               state_d = DONE;
               hits_d  = rco_cnt_inc;
            end else begin
               rem_d = rem_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      enable = (state_q == RUN);
      mode   = enable ? mode_q : 2'b00;
      D      = enable ? d_q : 4'h0;
      gnt0   = enable && first_q && !win_q;
      gnt1   = enable && first_q && win_q;
      done0  = (state_q == DONE) && !win_q;
      done1  = (state_q == DONE) && win_q;
      busy   = (state_q != IDLE);
      hits   = hits_q;
   end

endmodule

// File: tb/tb_contador_arb.sv
// Randomized scoreboard bench for contador_arb: the driver predicts each run from
// the arbitration rules, the monitor checks every grant, run cycle and done pulse.
module tb_contador_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1, rco;
   logic [1:0] mode0, mode1, mode;
   logic [3:0] D0, D1, len0, len1, D, hits;
   logic       gnt0, gnt1, done0, done1, enable, busy;

   contador_arb dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .mode0(mode0), .mode1(mode1), .D0(D0), .D1(D1),
      .len0(len0), .len1(len1), .rco(rco),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .enable(enable), .mode(mode), .D(D), .hits(hits), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         who;
      logic [1:0] m;
      logic [3:0] d;
      int         n;
      logic [3:0] h;
   } txn_t;

   txn_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   last_m = 1;
   int   cyc = 0;

   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   function automatic logic [3:0] popsat(input logic [15:0] p, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) c += int'(p[i]);
      return (c > 15) ? 4'hF : 4'(c);
   endfunction

   // Monitor
   txn_t       cur;
   bit         in_run = 0;
   int         runc = 0;
   logic [3:0] held_h = 4'h0;

   always @(negedge clk) begin
      if (!reset) begin
         in_run = 0;
         held_h = 4'h0;
         chk("rst_outputs", {gnt0, gnt1, done0, done1, enable, busy, mode, D, hits}, 0);
      end else begin
         chk("busy", busy, enable | done0 | done1);
         if (!enable) chk("idle_mode_D", {mode, D}, 0);
         if (gnt0 || gnt1) begin
            chk("gnt_onehot", gnt0 & gnt1, 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_gnt", 1, 0);
            end else begin
               cur = exp_q.pop_front();
               chk("gnt_who", gnt1 ? 1 : 0, cur.who);
               in_run = 1;
               runc = 0;
            end
         end
         if (in_run && enable) begin
            runc++;
            chk("run_mode", mode, cur.m);
            chk("run_D", D, cur.d);
         end
         if (done0 || done1) begin
            chk("done_onehot", done0 & done1, 0);
            chk("done_enable", enable, 0);
            if (!in_run) begin
               chk("unexpected_done", 1, 0);
            end else begin
               chk("done_who", done1 ? 1 : 0, cur.who);
               chk("run_len", runc, cur.n);
               chk("hits_done", hits, cur.h);
               held_h = cur.h;
               in_run = 0;
            end
         end else begin
            chk("hits_hold", hits, held_h);
         end
      end
   end

   // Driver
   task automatic await_gnt(input int who, output bit ok);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("gnt_timeout_for_req", -1, who);
   endtask

   // Starts in the first RUN cycle; ends just after the edge into DONE.
   task automatic drive_run(input int who, input int n, input logic [15:0] pat);
      if (who == 0) begin
         req0 = 0; mode0 = 2'($urandom); D0 = 4'($urandom); len0 = 4'($urandom);
      end else begin
         req1 = 0; mode1 = 2'($urandom); D1 = 4'($urandom); len1 = 4'($urandom);
      end
      for (int i = 0; i < n; i++) begin
         rco = pat[i];
         @(posedge clk);
         #1;
         if (who == 0) begin mode0 = 2'($urandom); D0 = 4'($urandom); end
         else          begin mode1 = 2'($urandom); D1 = 4'($urandom); end
      end
      rco = 0;
   endtask

   task automatic scenario(input bit u0, input bit u1,
                           input logic [1:0] m0, input logic [1:0] m1,
                           input logic [3:0] d0v, input logic [3:0] d1v,
                           input logic [3:0] l0, input logic [3:0] l1,
                           input logic [15:0] p0, input logic [15:0] p1);
      int   order[$];
      int   nn[2];
      int   prev_g;
      bit   ok;
      txn_t t;
      nn[0] = (l0 == 0) ? 16 : int'(l0);
      nn[1] = (l1 == 0) ? 16 : int'(l1);
      @(posedge clk);
      #1;
      req0 = u0; mode0 = m0; D0 = d0v; len0 = l0;
      req1 = u1; mode1 = m1; D1 = d1v; len1 = l1;
      if (u0 && u1) begin
         if (last_m == 1) begin order.push_back(0); order.push_back(1); end
         else             begin order.push_back(1); order.push_back(0); end
      end else begin
         order.push_back(u1 ? 1 : 0);
      end
      foreach (order[k]) begin
         t.who = order[k];
         t.m   = (order[k] == 1) ? m1 : m0;
         t.d   = (order[k] == 1) ? d1v : d0v;
         t.n   = nn[order[k]];
         t.h   = popsat((order[k] == 1) ? p1 : p0, t.n);
         exp_q.push_back(t);
      end
      last_m = order[order.size() - 1];
      prev_g = 0;
      foreach (order[k]) begin
         await_gnt(order[k], ok);
         if (!ok) begin
            req0 = 0; req1 = 0;
            exp_q.delete();
            return;
         end
         if (k > 0) chk("tie_grant_spacing", cyc - prev_g, nn[order[0]] + 2);
         prev_g = cyc;
         drive_run(order[k], nn[order[k]], (order[k] == 1) ? p1 : p0);
      end
   endtask

   task automatic reset_midrun();
      bit         ok;
      txn_t       t;
      logic [15:0] p;
      p = 16'($urandom);
      @(posedge clk);
      #1;
      req0 = 1; mode0 = 2'b10; D0 = 4'hA; len0 = 4'd6; req1 = 0;
      t.who = 0; t.m = 2'b10; t.d = 4'hA; t.n = 6; t.h = 4'h0;
      exp_q.push_back(t);
      await_gnt(0, ok);
      if (!ok) begin req0 = 0; exp_q.delete(); return; end
      rco = 1;
      @(posedge clk);
      #2;
      reset = 0;
      #1;
      chk("async_enable", enable, 0);
      chk("async_busy", busy, 0);
      chk("async_done", {done0, done1}, 0);
      chk("async_hits", hits, 0);
      rco = 0;
      last_m = 1;
      @(negedge clk);
      #1;
      reset = 1;
      t.h = popsat(p, 6);
      exp_q.push_back(t);
      last_m = 0;
      @(posedge clk);
      #1;
      chk("regrant_first_edge", gnt0, 1);
      drive_run(0, 6, p);
   endtask

   initial begin
      reset = 0; req0 = 0; req1 = 0; rco = 0;
      mode0 = 0; mode1 = 0; D0 = 0; D1 = 0; len0 = 0; len1 = 0;
      #1;
      chk("rst_async_busy", busy, 0);
      chk("rst_async_hits", hits, 0);
      repeat (3) @(negedge clk);
      #2;
      reset = 1;

      scenario(1, 0, 2'b01, 2'b00, 4'h5, 4'h0, 4'd3, 4'd0, 16'h0000, 16'h0000);
      scenario(1, 1, 2'b11, 2'b10, 4'h3, 4'hC, 4'd2, 4'd2, 16'h0003, 16'h0001);
      scenario(1, 1, 2'b01, 2'b01, 4'h9, 4'h6, 4'd2, 4'd2, 16'h0002, 16'h0000);
      scenario(0, 1, 2'b00, 2'b10, 4'h0, 4'h7, 4'd0, 4'd0, 16'h0000, 16'h5A5A);
      scenario(1, 0, 2'b10, 2'b00, 4'hE, 4'h0, 4'd8, 4'd0, 16'h00B5, 16'h0000);
      scenario(1, 0, 2'b11, 2'b00, 4'hF, 4'h0, 4'd0, 4'd0, 16'hFFFF, 16'h0000);
      reset_midrun();

      for (int i = 0; i < 40; i++) begin
         int u;
         u = int'($urandom_range(1, 3));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         scenario((u & 1) != 0, (u & 2) != 0,
                  2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("ended_outside_run", int'(in_run), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
